// File: rtl/mdr_mem_port_pkg.sv
// Shared definitions for the MDR / memory-port block.
//   - default data and address widths
//   - FSM state encoding for the memory handshake controller
package mdr_mem_port_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 9;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StWrWait = 2'd2
  } mdr_state_e;

endpackage

// File: rtl/mdr_mem_port_timeout.sv
// Wait-state timeout counter for the memory handshake.
//   clk_i     system clock
//   clear_i   synchronous active-high reset
//   load_i    restart the count at zero (on entry to a wait state)
//   en_i      count one wait cycle without acknowledge
//   expire_o  high when the current ack-less wait cycle is the Timeout-th one
// Timeout = 0 disables expiry entirely.
module mdr_mem_port_timeout #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((Timeout == 0) ? 0 : Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed ack-less cycles, so this cycle is number cnt_q + 1.
  assign expire_o = (Timeout != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mdr_mem_port.sv
// Memory Data Register with request/acknowledge memory-side controller.
//   clock, clear    rising-edge clock, synchronous active-high reset
//   BusMuxOut       bus value loaded into MDR on MDRin (Read=0)
//   MAR_addr        address latched at the start of a transaction
//   MDRin/Read/Write control-unit strobes, sampled only in idle
//   mem_rdata/ack   memory read data and completion acknowledge
//   BusMuxIn_MDR    MDR register value
//   mem_addr/wdata  latched transaction address / write data
//   mem_rd/mem_wr   level request lines
//   busy/done       transaction in progress / one-cycle completion pulse
//   mem_err         sticky: read/write conflict or timeout
module mdr_mem_port
  import mdr_mem_port_pkg::*;
#(
  parameter int unsigned DATA_W  = DataW,
  parameter int unsigned ADDR_W  = AddrW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] BusMuxIn_MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);

  mdr_state_e        state_q, state_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              cnt_load, cnt_en, expire;

  mdr_mem_port_timeout #(
    .Timeout (TIMEOUT)
  ) u_timeout (
    .clk_i    (clock),
    .clear_i  (clear),
    .load_i   (cnt_load),
    .en_i     (cnt_en),
    .expire_o (expire)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (MDRin && Read) begin
          state_d = StRdWait;
        end else if (Write) begin
          state_d = StWrWait;
        end
      end
      StRdWait, StWrWait: begin
        if (mem_ack || expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered-output next values. Strobes are ignored outside idle.
  always_comb begin
    mdr_d    = mdr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MDRin && Read) begin
          addr_d   = MAR_addr;
          rd_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          // A simultaneous write is dropped and flagged.
          if (Write) begin
            err_d = 1'b1;
          end
        end else if (Write) begin
          addr_d   = MAR_addr;
          wdata_d  = mdr_q;
          wr_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end else if (MDRin) begin
          mdr_d = BusMuxOut;
        end
      end
      StRdWait, StWrWait: begin
        cnt_en = !mem_ack;
        // Ack wins over a timeout reached in the same cycle.
        if (mem_ack || expire) begin
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
          if (mem_ack && state_q == StRdWait) begin
            mdr_d = mem_rdata;
          end
          if (!mem_ack) begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign BusMuxIn_MDR = mdr_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_rd       = rd_q;
  assign mem_wr       = wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed bench for mdr_mem_port (DATA_W=32, ADDR_W=9, TIMEOUT=15).
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_mdr_mem_port;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic [8:0]  MAR_addr = '0;
  logic        MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] BusMuxIn_MDR, mem_wdata;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr, busy, done, mem_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mdr_mem_port #(
    .DATA_W  (32),
    .ADDR_W  (9),
    .TIMEOUT (15)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .BusMuxOut    (BusMuxOut),
    .MAR_addr     (MAR_addr),
    .MDRin        (MDRin),
    .Read         (Read),
    .Write        (Write),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .BusMuxIn_MDR (BusMuxIn_MDR),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .busy         (busy),
    .done         (done),
    .mem_err      (mem_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    chk("rst_mdr", BusMuxIn_MDR, 32'h0);
    chk("rst_addr", {23'h0, mem_addr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'h0);

    // Bus load
    BusMuxOut = 32'hDEADBEEF;
    MDRin = 1'b1;
    tick();
    MDRin = 1'b0;
    chk("bus_mdr", BusMuxIn_MDR, 32'hDEADBEEF);
    chk("bus_busy_done", {30'h0, busy, done}, 32'h0);

    // Read, immediate ack
    MAR_addr = 9'h005;
    MDRin = 1'b1;
    Read = 1'b1;
    tick();  // cycle 1
    MDRin = 1'b0;
    Read = 1'b0;
    chk("rd_c1_ctl", {28'h0, mem_rd, mem_wr, busy, done}, 32'b1010);
    chk("rd_c1_addr", {23'h0, mem_addr}, 32'h5);
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    tick();  // cycle 2
    mem_ack = 1'b0;
    chk("rd_c2_ctl", {28'h0, mem_rd, mem_wr, busy, done}, 32'b0001);
    chk("rd_c2_mdr", BusMuxIn_MDR, 32'h12345678);
    tick();
    chk("rd_done_once", {31'h0, done}, 32'h0);

    // Write with three wait cycles
    BusMuxOut = 32'hA5A5A5A5;
    MDRin = 1'b1;
    tick();
    MDRin = 1'b0;
    MAR_addr = 9'h1FF;
    Write = 1'b1;
    tick();  // cycle 1
    Write = 1'b0;
    chk("wr_c1_ctl", {28'h0, mem_rd, mem_wr, busy, done}, 32'b0110);
    chk("wr_c1_addr", {23'h0, mem_addr}, 32'h1FF);
    chk("wr_c1_wdata", mem_wdata, 32'hA5A5A5A5);
    tick();  // cycle 2
    tick();  // cycle 3
    tick();  // cycle 4
    chk("wr_c4_ctl", {28'h0, mem_rd, mem_wr, busy, done}, 32'b0110);
    chk("wr_c4_stable", {mem_wdata[22:0], mem_addr}, {23'h25A5A5, 9'h1FF});
    mem_ack = 1'b1;
    tick();  // cycle 5
    mem_ack = 1'b0;
    chk("wr_c5_ctl", {28'h0, mem_rd, mem_wr, busy, done}, 32'b0001);
    chk("wr_c5_mdr", BusMuxIn_MDR, 32'hA5A5A5A5);

    // Busy lockout: bus load and write during RD_WAIT are ignored
    MAR_addr = 9'h010;
    MDRin = 1'b1;
    Read = 1'b1;
    tick();
    Read = 1'b0;
    BusMuxOut = 32'h1;
    Write = 1'b1;
    tick();
    MDRin = 1'b0;
    Write = 1'b0;
    chk("lock_mdr", BusMuxIn_MDR, 32'hA5A5A5A5);
    chk("lock_ctl", {28'h0, mem_rd, mem_wr, busy, done}, 32'b1010);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    chk("lock_end_mdr", BusMuxIn_MDR, 32'hCAFEF00D);
    chk("lock_end_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b00010);
    tick();

    // Read and Write together: read wins, error flagged
    MAR_addr = 9'h022;
    MDRin = 1'b1;
    Read = 1'b1;
    Write = 1'b1;
    tick();
    MDRin = 1'b0;
    Read = 1'b0;
    Write = 1'b0;
    chk("conf_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b10101);
    chk("conf_addr", {23'h0, mem_addr}, 32'h22);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADC0DE;
    tick();
    mem_ack = 1'b0;
    chk("conf_mdr", BusMuxIn_MDR, 32'h0BADC0DE);

    // Clear the sticky error
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("err_cleared", {31'h0, mem_err}, 32'h0);

    // Timeout: 15 ack-less wait cycles, done in cycle 16
    MAR_addr = 9'h033;
    MDRin = 1'b1;
    Read = 1'b1;
    tick();  // cycle 1
    MDRin = 1'b0;
    Read = 1'b0;
    for (int i = 2; i <= 15; i++) tick();
    chk("to_c15_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b10100);
    tick();  // cycle 16
    chk("to_c16_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b00011);
    chk("to_c16_mdr", BusMuxIn_MDR, 32'h0);
    tick();
    chk("to_c17_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b00001);

    // Good read afterwards keeps mem_err set
    MAR_addr = 9'h001;
    MDRin = 1'b1;
    Read = 1'b1;
    tick();
    MDRin = 1'b0;
    Read = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h00000077;
    tick();
    mem_ack = 1'b0;
    chk("post_to_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b00011);
    chk("post_to_mdr", BusMuxIn_MDR, 32'h77);

    // Clear in the second RD_WAIT cycle
    MAR_addr = 9'h044;
    MDRin = 1'b1;
    Read = 1'b1;
    tick();  // cycle 1
    MDRin = 1'b0;
    Read = 1'b0;
    tick();  // cycle 2
    clear = 1'b1;
    tick();  // cycle 3
    clear = 1'b0;
    chk("mid_clr_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b00000);
    chk("mid_clr_addr", {23'h0, mem_addr}, 32'h0);
    chk("mid_clr_mdr", BusMuxIn_MDR, 32'h0);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_mdr", BusMuxIn_MDR, 32'h0);
    chk("late_ack_ctl", {27'h0, mem_rd, mem_wr, busy, done, mem_err}, 32'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
